// File: rtl/mcpu_loader_if.sv
// Bus bundle for mcpu_loader: loader byte stream, status, CPU memory port and RAM port.
// slave is the loader's view; master is the surrounding system (stream source, CPU, RAM).
interface mcpu_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] cpu_adress;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_oe;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_adress;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_oe;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  start, in_data, in_valid, cpu_adress, cpu_wdata, cpu_oe, cpu_we, mem_rdata,
    output in_ready, busy, done, err, cpu_rst_n, cpu_rdata, mem_adress, mem_wdata, mem_oe, mem_we
  );

  modport master (
    output start, in_data, in_valid, cpu_adress, cpu_wdata, cpu_oe, cpu_we, mem_rdata,
    input  in_ready, busy, done, err, cpu_rst_n, cpu_rdata, mem_adress, mem_wdata, mem_oe, mem_we
  );
endinterface

// File: rtl/mcpu_loader.sv
// Boot loader for the 8-bit CPU: streams a program into the shared RAM, verifies a
// trailing checksum, then releases the CPU from reset and hands it the RAM bus.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset; CPU held in reset, waiting for start
// ST_LOAD  | waiting for the next stream byte (in_ready=1)
// ST_WRITE | one-cycle RAM write of the latched byte at addr
// ST_CHECK | waiting for the checksum byte (in_ready=1)
// ST_RUN   | checksum matched; CPU out of reset and owns the RAM bus
// ST_FAIL  | checksum mismatched; CPU held in reset, err set
module mcpu_loader #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  mcpu_loader_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WRITE, ST_CHECK, ST_RUN, ST_FAIL
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DATA_W-1:0] sum, sum_nx;
  logic [DATA_W-1:0] wreg, wreg_nx;
  logic              done_q, done_nx;
  logic              err_q, err_nx;
  logic              rstn_q, rstn_nx;

  logic              in_ready_c, busy_c, mem_oe_c, mem_we_c;
  logic [ADDR_W-1:0] mem_adress_c;
  logic [DATA_W-1:0] mem_wdata_c, cpu_rdata_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      sum    <= '0;
      wreg   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rstn_q <= 1'b0;
    end else begin
      state  <= state_nx;
      addr   <= addr_nx;
      sum    <= sum_nx;
      wreg   <= wreg_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      rstn_q <= rstn_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    sum_nx       = sum;
    wreg_nx      = wreg;
    done_nx      = done_q;
    err_nx       = err_q;
    rstn_nx      = rstn_q;
    in_ready_c   = 1'b0;
    busy_c       = 1'b0;
    mem_adress_c = addr;
    mem_wdata_c  = wreg;
    mem_oe_c     = 1'b1;
    mem_we_c     = 1'b1;
    cpu_rdata_c  = '0;

    case (state)
      ST_IDLE, ST_FAIL: begin
        if (bus.start) begin
          state_nx = ST_LOAD;
          addr_nx  = '0;
          sum_nx   = '0;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          rstn_nx  = 1'b0;
        end
      end
      ST_LOAD: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.in_valid) begin
          wreg_nx  = bus.in_data;
          sum_nx   = sum + bus.in_data;
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy_c   = 1'b1;
        mem_we_c = 1'b0;
        if (addr == LAST_ADDR) begin
          state_nx = ST_CHECK;
        end else begin
          addr_nx  = addr + ADDR_W'(1);
          state_nx = ST_LOAD;
        end
      end
      ST_CHECK: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_data == sum) begin
            state_nx = ST_RUN;
            done_nx  = 1'b1;
            rstn_nx  = 1'b1;
          end else begin
            state_nx = ST_FAIL;
            err_nx   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // CPU owns the RAM bus: straight combinational pass-through
        mem_adress_c = bus.cpu_adress;
        mem_wdata_c  = bus.cpu_wdata;
        mem_oe_c     = bus.cpu_oe;
        mem_we_c     = bus.cpu_we;
        cpu_rdata_c  = bus.mem_rdata;
        if (bus.start) begin
          state_nx = ST_LOAD;
          addr_nx  = '0;
          sum_nx   = '0;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          rstn_nx  = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.cpu_rst_n  = rstn_q;
  assign bus.cpu_rdata  = cpu_rdata_c;
  assign bus.mem_adress = mem_adress_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_oe     = mem_oe_c;
  assign bus.mem_we     = mem_we_c;

endmodule

// File: tb/tb_mcpu_loader.sv
// Self-checking bench for mcpu_loader: a table of load sessions checked against a RAM image,
// expected write sequence and checksum computed here, plus hand-written reset/restart sequences.
module tb_mcpu_loader;
  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int LEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcpu_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mcpu_loader #(.ADDR_W(AW), .DATA_W(DW), .LOAD_LEN(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int         pat;     // 0: incrementing, 1: random, 2: all 0xFF
    int         gapmax;
    logic [7:0] delta;   // added to the true checksum
    bit         noise;   // toggle start while the session is busy
    bit         exp_done;
    bit         exp_err;
    bit         exp_rstn;
  } vec_t;

  logic [DW-1:0] ram  [LEN];
  logic [DW-1:0] img  [LEN];
  logic [DW-1:0] sdata[LEN];
  wr_t           wr_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            we_double = 0;
  logic          prev_we_low = 1'b0;
  vec_t          vecs[6];

  assign bus.mem_rdata = ram[bus.mem_adress];

  // RAM model and write log; a write is taken when mem_we is low mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we === 1'b0) begin
      ram[bus.mem_adress] = bus.mem_wdata;
      wr_q.push_back({bus.mem_adress, bus.mem_wdata});
      if (prev_we_low) we_double++;
      prev_we_low = 1'b1;
    end else begin
      prev_we_low = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int t;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_wait: in_ready still low after %0d cycles, required high within 50", t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic fill_data(input int pat);
    for (int i = 0; i < LEN; i++)
      sdata[i] = (pat == 0) ? 8'(i) : (pat == 1) ? 8'($urandom) : 8'hFF;
  endtask

  function automatic logic [7:0] checksum();
    int s = 0;
    for (int i = 0; i < LEN; i++) s += int'(sdata[i]);
    return 8'(s % 256);
  endfunction

  task automatic start_session();
    @(negedge clk);
    wr_q.delete();
    we_double = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy",  32'(bus.busy), 1);
    check("start_ready", 32'(bus.in_ready), 1);
    check("start_done",  32'(bus.done), 0);
    check("start_err",   32'(bus.err), 0);
    check("start_rstn",  32'(bus.cpu_rst_n), 0);
    check("start_addr",  32'(bus.mem_adress), 0);
  endtask

  task automatic check_writes(input int n, input string tag);
    int bad = 0;
    check({tag, "_write_count"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++)
      if (wr_q[i].a !== AW'(i) || wr_q[i].d !== sdata[i]) bad++;
    check({tag, "_write_seq_errors"}, bad, 0);
  endtask

  task automatic run_session(input vec_t v);
    int bad = 0;
    fill_data(v.pat);
    start_session();
    for (int i = 0; i < LEN; i++)
      send_byte(sdata[i], $urandom_range(0, v.gapmax), v.noise);
    send_byte(checksum() + v.delta, $urandom_range(0, v.gapmax), v.noise);
    check("end_done", 32'(bus.done), 32'(v.exp_done));
    check("end_err",  32'(bus.err), 32'(v.exp_err));
    check("end_rstn", 32'(bus.cpu_rst_n), 32'(v.exp_rstn));
    check("end_busy", 32'(bus.busy), 0);
    check("end_ready", 32'(bus.in_ready), 0);
    check_writes(LEN, "sess");
    check("we_double_pulses", we_double, 0);
    for (int i = 0; i < LEN; i++) begin
      if (ram[i] !== sdata[i]) bad++;
      img[i] = sdata[i];
    end
    check("ram_image_errors", bad, 0);
  endtask

  task automatic cpu_run_check();
    logic [AW-1:0] r;
    logic [DW-1:0] x;
    r = AW'($urandom_range(0, LEN - 1));
    x = 8'($urandom);
    @(posedge clk); #1;
    bus.cpu_adress = r;
    bus.cpu_oe     = 1'b0;
    bus.cpu_we     = 1'b1;
    #1;
    check("run_mem_adress", 32'(bus.mem_adress), 32'(r));
    check("run_mem_oe",     32'(bus.mem_oe), 0);
    check("run_mem_we",     32'(bus.mem_we), 1);
    check("run_cpu_rdata",  32'(bus.cpu_rdata), 32'(img[r]));
    bus.cpu_wdata = x;
    bus.cpu_we    = 1'b0;
    #1;
    check("run_mem_we_pass", 32'(bus.mem_we), 0);
    check("run_mem_wdata",   32'(bus.mem_wdata), 32'(x));
    @(posedge clk); #1;
    bus.cpu_we = 1'b1;
    img[r] = x;
    #1;
    check("run_readback", 32'(bus.cpu_rdata), 32'(img[r]));
    bus.cpu_oe = 1'b1;
  endtask

  task automatic cpu_blocked_check();
    @(posedge clk); #1;
    bus.cpu_adress = 6'd5;
    bus.cpu_oe     = 1'b0;
    bus.cpu_we     = 1'b0;
    #1;
    check("blk_mem_we",    32'(bus.mem_we), 1);
    check("blk_mem_oe",    32'(bus.mem_oe), 1);
    check("blk_cpu_rdata", 32'(bus.cpu_rdata), 0);
    bus.cpu_oe = 1'b1;
    bus.cpu_we = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{pat: 0, gapmax: 0, delta: 8'h00, noise: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_rstn: 1'b1};
    vecs[1] = '{pat: 0, gapmax: 0, delta: 8'h01, noise: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_rstn: 1'b0};
    vecs[2] = '{pat: 0, gapmax: 5, delta: 8'h00, noise: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_rstn: 1'b1};
    vecs[3] = '{pat: 1, gapmax: 3, delta: 8'h00, noise: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_rstn: 1'b1};
    vecs[4] = '{pat: 2, gapmax: 1, delta: 8'h80, noise: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_rstn: 1'b0};
    vecs[5] = '{pat: 1, gapmax: 0, delta: 8'h00, noise: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_rstn: 1'b1};

    for (int i = 0; i < LEN; i++) begin
      ram[i] = 8'h00;
      img[i] = 8'h00;
    end
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.in_data    = 8'hA5;
    bus.in_valid   = 1'b1;
    bus.cpu_adress = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_oe     = 1'b1;
    bus.cpu_we     = 1'b1;

    // reset with a valid byte offered: nothing may be accepted or written
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    check("rst_mem_we",    32'(bus.mem_we), 1);
    check("rst_mem_oe",    32'(bus.mem_oe), 1);
    check("rst_in_ready",  32'(bus.in_ready), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_done",      32'(bus.done), 0);
    check("rst_err",       32'(bus.err), 0);
    check("rst_writes",    wr_q.size(), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_writes",   wr_q.size(), 0);
    check("idle_busy",     32'(bus.busy), 0);
    bus.in_valid = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_session(vecs[k]);
      if (vecs[k].exp_done) cpu_run_check();
      else cpu_blocked_check();
    end

    // restart from RUN, then reset partway through the reload
    fill_data(1);
    start_session();
    for (int i = 0; i < 10; i++)
      send_byte(sdata[i], $urandom_range(0, 2), 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_writes(10, "abort");
    check("abort_busy",  32'(bus.busy), 0);
    check("abort_ready", 32'(bus.in_ready), 0);
    check("abort_rstn",  32'(bus.cpu_rst_n), 0);
    check("abort_done",  32'(bus.done), 0);
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (ram[i] !== ((i < 10) ? sdata[i] : img[i])) bad++;
    check("abort_ram_image_errors", bad, 0);
    bus.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
